// File: rtl/pcont_iselctl.sv
// pcont_iselctl: instruction-select controller for the S-stage instruction
// register. Produces a one-hot ZERO/LOAD/HOLD select every cycle.
// It sequences pipeline holds, post-kill flush bubbles and fetch misses.
// It also tracks consecutive fetch misses with a sticky timeout flag.
//
// Handshake: none. The select is a pure combinational decode of the current
// inputs and state. The S-stage register acts on it at the next SYSCLK edge,
// which is also the edge on which every registered output here updates.
module pcont_iselctl #(
   parameter int KILL_BUBBLES = 2,
   parameter int MISS_LIMIT   = 255
) (
   input  logic       SYSCLK,
   input  logic       RESET_D2_R_N,
   input  logic       CLMI_RHOLD,
   input  logic       IF_VALID_I,
   input  logic       KILL_S_P,
   output logic [2:0] CLMI_SELINST_S_P,
   output logic       INST_VALID_S_R,
   output logic [7:0] MISS_CNT_R,
   output logic       MISS_TIMEOUT_R
);

   typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

   localparam logic [2:0] SEL_ZERO  = 3'b001;
   localparam logic [2:0] SEL_LOAD  = 3'b010;
   localparam logic [2:0] SEL_HOLD  = 3'b100;
   // The kill cycle itself is bubble 1, so the counter covers the rest.
   localparam logic [2:0] BCNT_INIT = 3'(KILL_BUBBLES - 1);
   localparam logic [7:0] MISS_MAX  = 8'(MISS_LIMIT);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] bcnt;
   logic [2:0] bcnt_nxt;
   logic       kpend;
   logic       kpend_nxt;
   logic       valid_nxt;
   logic [7:0] miss_nxt;
   logic       timeout_nxt;

   // Priority decode: hold, then kill (new or deferred), then bubble, then fetch.
   always_comb begin
      state_nxt        = state;
      bcnt_nxt         = bcnt;
      kpend_nxt        = kpend;
      valid_nxt        = INST_VALID_S_R;
      miss_nxt         = MISS_CNT_R;
      timeout_nxt      = MISS_TIMEOUT_R;
      CLMI_SELINST_S_P = SEL_ZERO;

      if (!RESET_D2_R_N) begin
         CLMI_SELINST_S_P = SEL_ZERO;
      end else if (CLMI_RHOLD) begin
         // Everything freezes; a kill seen now is remembered for later.
         CLMI_SELINST_S_P = SEL_HOLD;
         if (KILL_S_P) begin
            kpend_nxt = 1'b1;
         end
      end else if (KILL_S_P || kpend) begin
         CLMI_SELINST_S_P = SEL_ZERO;
         kpend_nxt        = 1'b0;
         valid_nxt        = 1'b0;
         miss_nxt         = 8'd0;
         if (KILL_BUBBLES > 1) begin
            bcnt_nxt  = BCNT_INIT;
            state_nxt = BUBBLE;
         end else begin
            bcnt_nxt  = 3'd0;
            state_nxt = RUN;
         end
      end else if (state == BUBBLE) begin
         // Fetch bus is ignored while flushing; miss count is left alone.
         CLMI_SELINST_S_P = SEL_ZERO;
         valid_nxt        = 1'b0;
         bcnt_nxt         = bcnt - 3'd1;
         if (bcnt == 3'd1) begin
            state_nxt = RUN;
         end
      end else if (IF_VALID_I) begin
         CLMI_SELINST_S_P = SEL_LOAD;
         valid_nxt        = 1'b1;
         miss_nxt         = 8'd0;
      end else begin
         CLMI_SELINST_S_P = SEL_ZERO;
         valid_nxt        = 1'b0;
         if (MISS_CNT_R >= MISS_MAX) begin
            miss_nxt = MISS_MAX;
         end else begin
            miss_nxt = MISS_CNT_R + 8'd1;
         end
         if (miss_nxt == MISS_MAX) begin
            timeout_nxt = 1'b1;
         end
      end
   end

   // State and output registers; reset is asynchronous so it also drops kpend.
   always_ff @(posedge SYSCLK or negedge RESET_D2_R_N) begin
      if (!RESET_D2_R_N) begin
         state          <= RUN;
         bcnt           <= 3'd0;
         kpend          <= 1'b0;
         INST_VALID_S_R <= 1'b0;
         MISS_CNT_R     <= 8'd0;
         MISS_TIMEOUT_R <= 1'b0;
      end else begin
         state          <= state_nxt;
         bcnt           <= bcnt_nxt;
         kpend          <= kpend_nxt;
         INST_VALID_S_R <= valid_nxt;
         MISS_CNT_R     <= miss_nxt;
         MISS_TIMEOUT_R <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_pcont_iselctl.sv
// Testbench for pcont_iselctl with KILL_BUBBLES = 3 and MISS_LIMIT = 4.
module tb_pcont_iselctl;

   localparam int KB = 3;
   localparam int ML = 4;
   localparam logic [2:0] Z = 3'b001;
   localparam logic [2:0] L = 3'b010;
   localparam logic [2:0] H = 3'b100;

   // clock / reset / stimulus signals
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       hold  = 1'b0;
   logic       ifv   = 1'b0;
   logic       kill  = 1'b0;
   logic [2:0] sel;
   logic       ival;
   logic [7:0] mcnt;
   logic       mto;

   always #5 clk = ~clk;

   pcont_iselctl #(.KILL_BUBBLES(KB), .MISS_LIMIT(ML)) dut (
      .SYSCLK           (clk),
      .RESET_D2_R_N     (rst_n),
      .CLMI_RHOLD       (hold),
      .IF_VALID_I       (ifv),
      .KILL_S_P         (kill),
      .CLMI_SELINST_S_P (sel),
      .INST_VALID_S_R   (ival),
      .MISS_CNT_R       (mcnt),
      .MISS_TIMEOUT_R   (mto)
   );

   int total = 0;
   int bad   = 0;

   // scoreboard: expected select sequence for scenario tests
   logic [2:0] exp_q[$];

   // reference model: counts remaining forced-zero cycles after a kill
   int         m_zeros;
   bit         m_kp;
   bit         m_val;
   int         m_miss;
   bit         m_to;
   logic [2:0] m_sel;

   // observed values of the last cycle
   logic [2:0] obs_sel;
   logic       obs_val;
   logic [7:0] obs_miss;
   logic       obs_to;

   task automatic model_reset();
      m_zeros = 0;
      m_kp    = 0;
      m_val   = 0;
      m_miss  = 0;
      m_to    = 0;
   endtask

   task automatic model_step();
      if (!rst_n) begin
         m_sel = Z;
         model_reset();
      end else if (hold) begin
         m_sel = H;
         if (kill) m_kp = 1;
      end else if (kill || m_kp) begin
         m_sel   = Z;
         m_kp    = 0;
         m_val   = 0;
         m_miss  = 0;
         m_zeros = KB - 1;
      end else if (m_zeros > 0) begin
         m_sel   = Z;
         m_val   = 0;
         m_zeros = m_zeros - 1;
      end else if (ifv) begin
         m_sel  = L;
         m_val  = 1;
         m_miss = 0;
      end else begin
         m_sel = Z;
         m_val = 0;
         if (m_miss < ML) m_miss = m_miss + 1;
         if (m_miss == ML) m_to = 1;
      end
   endtask

   // driver: one clock cycle of stimulus; select sampled mid-cycle, regs after edge
   task automatic cycle(input logic r, input logic h, input logic v, input logic k);
      @(negedge clk);
      rst_n = r;
      hold  = h;
      ifv   = v;
      kill  = k;
      #1;
      obs_sel = sel;
      model_step();
      @(posedge clk);
      #1;
      obs_val  = ival;
      obs_miss = mcnt;
      obs_to   = mto;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b0);
         total++;
         if (obs_sel !== Z) begin
            bad++;
            $display("FAIL reset_sel: got %b want %b", obs_sel, Z);
         end
         total++;
         if ({obs_val, obs_miss, obs_to} !== 10'd0) begin
            bad++;
            $display("FAIL reset_regs: got val=%b miss=%0d to=%b want all 0", obs_val, obs_miss, obs_to);
         end
      end
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b1, 1'b0);
         total++;
         if (obs_sel !== L || obs_val !== 1'b1) begin
            bad++;
            $display("FAIL steady_fetch: got sel=%b val=%b want sel=%b val=1", obs_sel, obs_val, L);
         end
      end
   endtask

   task automatic test_kill();
      logic ks[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic vs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [2:0] e;
      exp_q.push_back(Z); exp_q.push_back(Z); exp_q.push_back(Z);
      exp_q.push_back(L); exp_q.push_back(L);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b1, ks[i]);
         e = exp_q.pop_front();
         total++;
         if (obs_sel !== e || obs_val !== vs[i]) begin
            bad++;
            $display("FAIL kill_bubbles[%0d]: got sel=%b val=%b want sel=%b val=%b", i, obs_sel, obs_val, e, vs[i]);
         end
      end
   endtask

   task automatic test_kill_hold();
      logic hs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic ks[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic vs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [2:0] e;
      exp_q.push_back(H); exp_q.push_back(H); exp_q.push_back(H); exp_q.push_back(H);
      exp_q.push_back(Z); exp_q.push_back(Z); exp_q.push_back(Z); exp_q.push_back(L);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, hs[i], 1'b1, ks[i]);
         e = exp_q.pop_front();
         total++;
         if (obs_sel !== e || obs_val !== vs[i]) begin
            bad++;
            $display("FAIL kill_under_hold[%0d]: got sel=%b val=%b want sel=%b val=%b", i, obs_sel, obs_val, e, vs[i]);
         end
      end
   endtask

   task automatic test_hold_bubble();
      logic hs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic ks[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [2:0] e;
      exp_q.push_back(Z); exp_q.push_back(H); exp_q.push_back(H);
      exp_q.push_back(Z); exp_q.push_back(Z); exp_q.push_back(L);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, hs[i], 1'b1, ks[i]);
         e = exp_q.pop_front();
         total++;
         if (obs_sel !== e) begin
            bad++;
            $display("FAIL hold_mid_bubble[%0d]: got %b want %b", i, obs_sel, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic ks[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [2:0] e;
      exp_q.push_back(Z); exp_q.push_back(Z); exp_q.push_back(Z);
      exp_q.push_back(Z); exp_q.push_back(L);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b1, ks[i]);
         e = exp_q.pop_front();
         total++;
         if (obs_sel !== e) begin
            bad++;
            $display("FAIL back_to_back_kill[%0d]: got %b want %b", i, obs_sel, e);
         end
      end
   endtask

   task automatic test_miss();
      int em[6] = '{1, 2, 3, 4, 4, 4};
      logic et[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
         total++;
         if (obs_sel !== Z || obs_miss !== 8'(em[i]) || obs_to !== et[i]) begin
            bad++;
            $display("FAIL miss_sat[%0d]: got sel=%b cnt=%0d to=%b want sel=%b cnt=%0d to=%b",
                     i, obs_sel, obs_miss, obs_to, Z, em[i], et[i]);
         end
      end
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      total++;
      if (obs_sel !== L || obs_miss !== 8'd0 || obs_to !== 1'b1) begin
         bad++;
         $display("FAIL miss_clear: got sel=%b cnt=%0d to=%b want sel=%b cnt=0 to=1", obs_sel, obs_miss, obs_to, L);
      end
   endtask

   task automatic test_reset_mid_bubble();
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      // now in bubble 1: hit reset mid-cycle, away from any edge
      @(negedge clk);
      kill = 1'b0;
      ifv  = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      total++;
      if (sel !== Z || ival !== 1'b0 || mcnt !== 8'd0 || mto !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_bubble: got sel=%b val=%b cnt=%0d to=%b want sel=001 rest 0", sel, ival, mcnt, mto);
      end
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      total++;
      if (obs_sel !== L || obs_val !== 1'b1) begin
         bad++;
         $display("FAIL load_after_reset: got sel=%b val=%b want sel=%b val=1", obs_sel, obs_val, L);
      end
   endtask

   task automatic test_random();
      logic r, h, v, k;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 49) != 0);
         h = ($urandom_range(0, 3) == 0);
         v = ($urandom_range(0, 9) < 5);
         k = ($urandom_range(0, 11) == 0);
         cycle(r, h, v, k);
         total++;
         if (obs_sel !== m_sel || !$onehot(obs_sel)) begin
            bad++;
            $display("FAIL rand_sel[%0d]: got %b want %b", i, obs_sel, m_sel);
         end
         total++;
         if (obs_val !== m_val || obs_miss !== 8'(m_miss) || obs_to !== m_to) begin
            bad++;
            $display("FAIL rand_regs[%0d]: got val=%b cnt=%0d to=%b want val=%b cnt=%0d to=%b",
                     i, obs_val, obs_miss, obs_to, m_val, m_miss, m_to);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_kill();
      test_kill_hold();
      test_hold_bubble();
      test_back_to_back();
      test_miss();
      test_reset_mid_bubble();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
